// File: rtl/sm_regdump_pkg.sv
// ---------------------------------------------------------------------------
// sm_regdump_pkg
// Shared definitions for the register-dump block: FSM state encodings,
// UART frame length, bytes per dumped word, number of debug registers and a
// byte-select helper for the word/byte mux.
// ---------------------------------------------------------------------------
package sm_regdump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_LATCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int FRAME_LEN      = 10;   // start + 8 data + stop
    localparam int BYTES_PER_WORD = 4;
    localparam int NUM_REGS       = 32;
    localparam int IDX_W          = $clog2(NUM_REGS);

    // Byte 0 is the most significant byte: words go out MSB byte first.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sm_regdump_if.sv
// ---------------------------------------------------------------------------
// sm_regdump_if
// Bundles the dump request/status, the CPU debug-register port and the UART
// line of sm_regdump.
//   start   : dump request (to dump engine)
//   regAddr : debug register index (from dump engine)
//   regData : debug register data, combinational on regAddr (to dump engine)
//   tx      : UART 8N1 line, idle high (from dump engine)
//   busy    : dump in progress (from dump engine)
//   done    : one-cycle completion pulse (from dump engine)
// slave  modport: the dump engine; master modport: the CPU/host side.
// ---------------------------------------------------------------------------
interface sm_regdump_if;
    logic        start;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic        tx;
    logic        busy;
    logic        done;

    modport slave  (input  start, input  regData,
                    output regAddr, output tx, output busy, output done);
    modport master (output start, output regData,
                    input  regAddr, input  tx, input  busy, input  done);
endinterface

// File: rtl/sm_uart_tx.sv
// ---------------------------------------------------------------------------
// sm_uart_tx
// UART 8N1 serialiser. A byte is taken when valid && ready; the frame is a
// 0 start bit, 8 data bits LSB first and a 1 stop bit, each BAUD_DIV cycles.
//   clk, rst : clock, synchronous active-high reset
//   data     : byte to send
//   valid    : data is offered
//   ready    : serialiser idle, will take data this cycle
//   tx       : serial line, idle high (registered)
// ---------------------------------------------------------------------------
module sm_uart_tx
    import sm_regdump_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    logic        r_busy;
    logic [15:0] r_baud;
    logic [3:0]  r_bit;     // frame bit currently on the line
    logic [8:0]  r_shift;   // remaining data bits with the stop bit on top
    logic        r_tx;
    logic        w_tick;

    assign w_tick = (r_baud == 16'(BAUD_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '1;
            r_tx    <= 1'b1;
        end else if (!r_busy) begin
            if (valid) begin
                // start bit goes out the same edge the byte is taken
                r_busy  <= 1'b1;
                r_shift <= {1'b1, data};
                r_tx    <= 1'b0;
                r_baud  <= '0;
                r_bit   <= '0;
            end
        end else if (w_tick) begin
            r_baud <= '0;
            if (r_bit == 4'(FRAME_LEN - 1)) begin
                r_busy <= 1'b0;
                r_tx   <= 1'b1;
                r_bit  <= '0;
            end else begin
                r_tx    <= r_shift[0];
                r_shift <= {1'b1, r_shift[8:1]};
                r_bit   <= r_bit + 1'b1;
            end
        end else begin
            r_baud <= r_baud + 1'b1;
        end
    end

    assign ready = !r_busy;
    assign tx    = r_tx;

endmodule

// File: rtl/sm_regdump.sv
// ---------------------------------------------------------------------------
// sm_regdump
// On a start request, reads CPU debug registers 0..31 through the debug port
// and sends each word over UART as 4 bytes, MSB byte first, then pulses done.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sm_regdump_if.slave (start, regAddr, regData, tx, busy, done)
// ---------------------------------------------------------------------------
module sm_regdump
    import sm_regdump_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic           clk,
    input  logic           rst,
    sm_regdump_if.slave    bus
);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_regAddr;
    logic [1:0]       r_byte;
    logic [31:0]      r_word;
    logic             r_busy;
    logic             r_done;

    logic             w_valid;
    logic             w_ready;
    logic [7:0]       w_data;
    logic             w_tx;

    assign w_valid = (r_state == ST_SEND);
    assign w_data  = word_byte(r_word, r_byte);

    sm_uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .data  (w_data),
        .valid (w_valid),
        .ready (w_ready),
        .tx    (w_tx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_regAddr <= '0;
            r_byte    <= '0;
            r_word    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state   <= ST_ADDR;
                        r_busy    <= 1'b1;
                        r_regAddr <= r_idx;
                    end
                end
                ST_ADDR:  r_state <= ST_LATCH;
                ST_LATCH: begin
                    // regAddr still holds the index, so regData is this word
                    r_word  <= bus.regData;
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_ready) begin
                        if (r_byte == 2'(BYTES_PER_WORD - 1)) begin
                            r_byte  <= '0;
                            r_state <= ST_NEXT;
                        end else begin
                            r_byte <= r_byte + 1'b1;
                        end
                    end
                end
                ST_NEXT: begin
                    if (r_idx < IDX_W'(NUM_REGS - 1)) begin
                        r_idx     <= r_idx + 1'b1;
                        r_regAddr <= r_idx + 1'b1;
                        r_state   <= ST_ADDR;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // last byte is still on the line; finish only once its
                    // stop bit has gone out
                    if (w_ready) begin
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_idx     <= '0;
                        r_regAddr <= '0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.regAddr = r_regAddr;
    assign bus.tx      = w_tx;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule

// File: tb/tb_sm_regdump.sv
// ---------------------------------------------------------------------------
// tb_sm_regdump
// Bench for sm_regdump with BAUD_DIV=4 and a CPU model returning
// 32'hA5000000 | regAddr. A line receiver checks every frame's timing and
// byte against a queue of expected bytes built from the dump rules.
// ---------------------------------------------------------------------------
module tb_sm_regdump;
    import sm_regdump_pkg::*;

    localparam int B = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sm_regdump_if bus();
    assign bus.regData = 32'hA500_0000 | {27'd0, bus.regAddr};

    sm_regdump #(.BAUD_DIV(B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected byte stream of one whole dump.
    function automatic void build_model();
        logic [31:0] w;
        exp_q.delete();
        for (int r = 0; r < NUM_REGS; r++) begin
            w = 32'hA500_0000 | 32'(r);
            for (int k = BYTES_PER_WORD - 1; k >= 0; k--)
                exp_q.push_back(8'((w >> (8 * k)) & 32'hFF));
        end
    endfunction

    task automatic idle_checks(input string tag);
        check({tag, "_tx"},      32'(bus.tx),      32'd1);
        check({tag, "_busy"},    32'(bus.busy),    32'd0);
        check({tag, "_done"},    32'(bus.done),    32'd0);
        check({tag, "_regAddr"}, 32'(bus.regAddr), 32'd0);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Receives one frame. gap = negedges waited before the start bit.
    // Each bit must hold one value for exactly B samples; start 0, stop 1.
    task automatic rx_frame(output logic [7:0] b, output bit ok, output int gap);
        logic v;
        ok = 1'b1; b = '0; gap = 0; v = 1'b0;
        while (bus.tx !== 1'b0 && gap < 200) begin
            @(negedge clk);
            gap++;
        end
        if (bus.tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        for (int bi = 0; bi < FRAME_LEN; bi++) begin
            for (int k = 0; k < B; k++) begin
                if (k == 0) v = bus.tx;
                else if (bus.tx !== v) ok = 1'b0;
                if (!(bi == FRAME_LEN - 1 && k == B - 1)) @(negedge clk);
            end
            if (bi == 0 && v !== 1'b0) ok = 1'b0;
            if (bi == FRAME_LEN - 1 && v !== 1'b1) ok = 1'b0;
            if (bi > 0 && bi < FRAME_LEN - 1) b[bi-1] = v;
        end
    endtask

    // Receives nframes frames of a dump, optionally pulsing start during two
    // chosen frames; stops early if the line goes silent.
    task automatic rx_frames(input int nframes, input int inj_a, input int inj_b, input string tag);
        logic [7:0] b;
        bit ok;
        int gap;
        for (int i = 0; i < nframes; i++) begin
            if (i == inj_a || i == inj_b) begin
                fork
                    begin
                        repeat (6) @(negedge clk);
                        bus.start = 1'b1;
                        @(negedge clk);
                        bus.start = 1'b0;
                    end
                join_none
            end
            rx_frame(b, ok, gap);
            check($sformatf("%s_timing%0d", tag, i), 32'(ok), 32'd1);
            check($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(exp_q[i]));
            if (i > 0) check($sformatf("%s_gap%0d", tag, i), 32'(gap <= 2), 32'd1);
            if (gap >= 200) break;
        end
    endtask

    // Full dump: 128 frames, no early done, then a single done with busy low.
    task automatic rx_dump(input int inj_a, input int inj_b, input string tag);
        int d0;
        int n;
        d0 = done_cnt;
        build_model();
        rx_frames(NUM_REGS * BYTES_PER_WORD, inj_a, inj_b, tag);
        check({tag, "_no_early_done"}, 32'(done_cnt), 32'(d0));
        n = 0;
        while (bus.done !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
        check({tag, "_busy_fell"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        bit ok;
        int gap;
        int lows;
        int inj;
        int dsnap;

        rst = 1'b1;
        bus.start = 1'b0;

        // reset held two cycles, outputs quiet throughout and after
        repeat (2) begin
            @(negedge clk);
            idle_checks("reset");
        end
        rst = 1'b0;
        repeat ($urandom_range(1, 8)) @(negedge clk);
        idle_checks("post_reset");

        // dump 1: single start pulse
        pulse_start();
        check("busy_after_start", 32'(bus.busy), 32'd1);
        rx_dump(-1, -1, "dump1");
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        repeat (3) @(negedge clk);
        idle_checks("after_dump1");
        check("done_count1", 32'(done_cnt), 32'd1);

        // dump 2: extra start pulses during frame 10 and a random later frame
        repeat ($urandom_range(1, 10)) @(negedge clk);
        inj = $urandom_range(20, 120);
        pulse_start();
        rx_dump(10, inj, "dump2");
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.tx !== 1'b1) lows++;
        end
        check("no_extra_dump", 32'(lows), 32'd0);
        check("done_count2", 32'(done_cnt), 32'd2);

        // dump 3: reset during frame 50, 2nd data bit
        repeat ($urandom_range(1, 10)) @(negedge clk);
        pulse_start();
        build_model();
        rx_frames(50, -1, -1, "dump3");
        gap = 0;
        while (bus.tx !== 1'b0 && gap < 200) begin
            @(negedge clk);
            gap++;
        end
        check("frame50_start", 32'(bus.tx), 32'd0);
        repeat (2 * B + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        idle_checks("mid_reset");
        rst = 1'b0;
        dsnap = done_cnt;
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) lows++;
        end
        check("aborted_quiet", 32'(lows), 32'd0);
        check("aborted_no_done", 32'(done_cnt), 32'(dsnap));

        // dump 4: start held high; restarts at index 0, then chains a new dump
        bus.start = 1'b1;
        rx_dump(-1, -1, "dump4");
        rx_frame(b, ok, gap);
        check("held_timing", 32'(ok), 32'd1);
        check("held_byte", 32'(b), 32'hA5);
        // done cycle, then the start bit within 3 cycles of done dropping
        check("held_latency", 32'(gap <= 4), 32'd1);
        bus.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        idle_checks("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sm_regdump.md
SM_REGDUMP -- requirements
Module: sm_regdump

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 434, meaning clk cycles per UART bit (range 2..65535).
REQ-002 SHALL have port clk  input  1  the single clock; all logic on posedge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  dump request; sampled every cycle.
REQ-005 SHALL have port regAddr  output  5  debug register address driven to the CPU debug port.
REQ-006 SHALL have port regData  input  32  debug register data from the CPU; combinational, valid in the same cycle as regAddr.
REQ-007 SHALL have port tx  output  1  UART 8N1 serial output; idle high.
REQ-008 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the last frame's stop bit.

Function
REQ-010 SHALL accept start only in IDLE; start in any other state SHALL be ignored.
REQ-011 SHALL dump debug indices 0..31 in ascending order; index 0 returns the CPU pc and SHALL be transmitted like any other word.
REQ-012 SHALL use FSM states IDLE -> ADDR -> LATCH -> SEND -> (NEXT -> ADDR | DONE) -> IDLE.
REQ-013 ADDR: SHALL drive regAddr = index for one cycle.
REQ-014 LATCH: SHALL capture regData into a 32-bit word register while regAddr still holds index.
REQ-015 SEND: SHALL transmit the latched word as 4 bytes, MSB byte first: [31:24], [23:16], [15:8], [7:0].
REQ-016 SEND: SHALL hand each byte to the transmitter only when the transmitter is ready; byte counter SHALL wrap 3 -> 0 on leaving SEND.
REQ-017 NEXT: SHALL go to ADDR with index+1 if index < 31, else to DONE; index SHALL never wrap within one dump.
REQ-018 DONE: SHALL assert done for exactly one cycle, then return to IDLE with index = 0.
REQ-019 Each frame SHALL be a start bit 0, data bits LSB first, then stop bit 1.
REQ-020 Each bit SHALL last exactly BAUD_DIV cycles, so each frame lasts 10*BAUD_DIV cycles.
REQ-021 Consecutive frames within one word SHALL have at most 1 idle-high cycle between stop bit and the next start bit.
REQ-022 A full dump SHALL emit exactly 128 frames.
REQ-023 start held high continuously SHALL begin a new dump the cycle after DONE returns to IDLE.
REQ-024 In IDLE, regAddr SHALL be 0 and tx SHALL be 1.

Reset
REQ-025 On rst=1 at posedge, state SHALL go to IDLE.
REQ-026 On reset, tx=1, busy=0, done=0, regAddr=0, and index, byte counter, baud counter and bit counter SHALL all be 0.
REQ-027 Reset mid-frame SHALL force tx=1 from the next cycle, abort the dump, and suppress done.
REQ-028 rst SHALL take priority over start in the same cycle.

Structure
REQ-029 The shared header SHALL hold the FSM state encodings, the frame length (10), the bytes-per-word value (4) and the register count (32).
REQ-030 A sub-module sm_uart_tx SHALL implement the serialiser, with ports clk, rst, data[7:0], valid, ready, tx and parameter BAUD_DIV.
REQ-031 sm_uart_tx SHALL take data when valid and ready are both high.
REQ-032 The dump FSM and word/byte muxing SHALL live in sm_regdump.

Verification (BAUD_DIV=4; CPU model regData = 32'hA5000000 | regAddr)
REQ-033 Reset: rst high 2 cycles -> tx=1, busy=0, done=0, regAddr=0 throughout and after.
REQ-034 Full dump: one start pulse -> 128 frames; bytes A5,00,00,00, A5,00,00,01 ... A5,00,00,1F; then exactly one done pulse and busy falls.
REQ-035 Bit timing: first frame (0xA5) -> tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 each 4 cycles, then high 4 cycles.
REQ-036 Ignored start: extra start pulse during frame 10 -> still 128 frames and one done.
REQ-037 Reset mid-dump: rst during frame 50 at the 2nd data bit -> tx=1 next cycle, busy=0, no done; a new start then restarts at index 0 with byte A5.
REQ-038 Held start: start tied high -> second dump's first start bit begins within 3 cycles after the first done.
